// File: rtl/uart_rx_deser.sv
// uart_rx_deser: oversampling UART receive deserializer feeding the RBR/LSR
// register block. Synchronises rx, qualifies the start bit, majority-votes
// each bit around mid-bit, assembles 5-8 data bits with optional parity and
// reports each character as a one-cycle valid pulse with error status.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | line idle; waiting for a low sample while armed
// S_START  | start bit in progress; mid-bit vote rejects glitches
// S_DATA   | data bits, LSB first, bcnt selects the bit position
// S_PARITY | parity bit (only when parity was enabled at frame start)
// S_STOP   | stop bit; status is decided at the mid-bit vote
module uart_rx_deser #(
  parameter int SYNC_STAGES = 2,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       baud_tick,
  input  logic       rx,
  input  logic [1:0] lcr_wls,
  input  logic       lcr_pen,
  input  logic       lcr_eps,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_break,
  output logic       rx_active
);

  localparam int TW = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] L_TLAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] L_SMP0  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] L_SMP1  = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] L_VOTE  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] L_ONE   = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } t_state;

  logic [SYNC_STAGES-1:0] r_sync;
  t_state                 r_state;
  logic [TW-1:0]          r_tcnt;
  logic [2:0]             r_bcnt;
  logic                   r_s0;
  logic                   r_s1;
  logic [7:0]             r_shift;
  logic                   r_par;
  logic                   r_armed;
  logic [1:0]             r_cfg_wls;
  logic                   r_cfg_pen;
  logic                   r_cfg_eps;
  logic [7:0]             r_rx_data;
  logic                   r_rx_valid;
  logic                   r_parity_err;
  logic                   r_frame_err;
  logic                   r_break;

  logic                   w_rxs;
  logic                   w_vote;
  logic                   w_last;
  logic                   w_maj;
  logic [2:0]             w_last_bit;
  logic                   w_xor;
  logic                   w_parity_err;
  logic                   w_break;

  // Input synchroniser; flops reset to the idle (mark) level so reset never
  // looks like a start bit.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
    end
  end

  assign w_rxs = r_sync[SYNC_STAGES-1];

  // Vote point and bit-end point within the current bit
  assign w_vote = baud_tick && (r_tcnt == L_VOTE);
  assign w_last = baud_tick && (r_tcnt == L_TLAST);

  // 2-of-3 majority: two earlier captures plus the live sample at the vote
  assign w_maj = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);

  // Index of the final data bit: wls 00..11 -> 4..7
  assign w_last_bit = 3'({1'b0, r_cfg_wls}) + 3'd4;

  // Unused upper data bits stay 0, so they do not disturb the parity sum
  assign w_xor        = ^{r_shift, r_par};
  assign w_parity_err = r_cfg_pen & (r_cfg_eps ? w_xor : ~w_xor);
  assign w_break      = (r_shift == 8'h00) & (~r_cfg_pen | ~r_par) & ~w_maj;

  // Receive FSM with tick counter, bit counter, sampling and status outputs
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state      <= S_IDLE;
      r_tcnt       <= '0;
      r_bcnt       <= '0;
      r_s0         <= 1'b1;
      r_s1         <= 1'b1;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_armed      <= 1'b1;
      r_cfg_wls    <= '0;
      r_cfg_pen    <= 1'b0;
      r_cfg_eps    <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_break      <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (baud_tick) begin
        if (r_state == S_IDLE) begin
          if (w_rxs) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            // Config is frozen for the whole frame
            r_cfg_wls <= lcr_wls;
            r_cfg_pen <= lcr_pen;
            r_cfg_eps <= lcr_eps;
            r_tcnt    <= L_ONE;
            r_bcnt    <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_state   <= S_START;
          end
        end else begin
          r_tcnt <= r_tcnt + L_ONE;
          if (r_tcnt == L_SMP0) begin
            r_s0 <= w_rxs;
          end
          if (r_tcnt == L_SMP1) begin
            r_s1 <= w_rxs;
          end
          case (r_state)
            S_START: begin
              if (w_vote && w_maj) begin
                r_tcnt  <= '0;
                r_state <= S_IDLE;
              end else if (w_last) begin
                r_bcnt  <= '0;
                r_state <= S_DATA;
              end
            end
            S_DATA: begin
              if (w_vote) begin
                r_shift[r_bcnt] <= w_maj;
              end
              if (w_last) begin
                if (r_bcnt == w_last_bit) begin
                  r_state <= r_cfg_pen ? S_PARITY : S_STOP;
                end else begin
                  r_bcnt <= r_bcnt + 3'd1;
                end
              end
            end
            S_PARITY: begin
              if (w_vote) begin
                r_par <= w_maj;
              end
              if (w_last) begin
                r_state <= S_STOP;
              end
            end
            S_STOP: begin
              // Leave at mid stop bit to gain half a bit of resync margin
              if (w_vote) begin
                r_rx_data    <= r_shift;
                r_rx_valid   <= 1'b1;
                r_parity_err <= w_parity_err;
                r_frame_err  <= ~w_maj;
                r_break      <= w_break;
                r_armed      <= w_maj;
                r_tcnt       <= '0;
                r_state      <= S_IDLE;
              end
            end
            default: begin
              r_tcnt  <= '0;
              r_state <= S_IDLE;
            end
          endcase
        end
      end
    end
  end

  assign rx_data       = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign rx_parity_err = r_parity_err;
  assign rx_frame_err  = r_frame_err;
  assign rx_break      = r_break;
  assign rx_active     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: 16x oversampling, one tick every 4 PCLK,
// so one bit lasts 64 PCLK cycles.
module tb_uart_rx_deser;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] lcr_wls = 2'b11;
  logic       lcr_pen = 1'b0;
  logic       lcr_eps = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_break;
  logic       rx_active;

  int n_cmp = 0;
  int n_mis = 0;

  int unsigned cyc = 0;
  int unsigned t_stop = 0;

  int          v_cnt = 0;
  int          v0;
  logic [7:0]  cap_data = 8'h00;
  logic        cap_pe = 1'b0;
  logic        cap_fe = 1'b0;
  logic        cap_brk = 1'b0;
  logic        cap_act = 1'b0;
  logic        cap_prev_act = 1'b0;
  int unsigned cap_cyc = 0;
  logic        prev_act = 1'b0;

  uart_rx_deser #(.SYNC_STAGES(2), .OVERSAMPLE(16)) dut (
    .PCLK         (PCLK),
    .PRESETn      (PRESETn),
    .baud_tick    (baud_tick),
    .rx           (rx),
    .lcr_wls      (lcr_wls),
    .lcr_pen      (lcr_pen),
    .lcr_eps      (lcr_eps),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err),
    .rx_break     (rx_break),
    .rx_active    (rx_active)
  );

  always #5 PCLK = ~PCLK;

  // Baud tick: one PCLK in four
  initial begin
    forever begin
      @(negedge PCLK);
      cyc = cyc + 1;
      baud_tick = ((cyc % 4) == 0);
    end
  end

  // Capture every valid pulse; a stuck valid shows up as extra pulses
  always @(negedge PCLK) begin
    if (rx_valid) begin
      v_cnt        = v_cnt + 1;
      cap_data     = rx_data;
      cap_pe       = rx_parity_err;
      cap_fe       = rx_frame_err;
      cap_brk      = rx_break;
      cap_act      = rx_active;
      cap_prev_act = prev_act;
      cap_cyc      = cyc;
    end
    prev_act = rx_active;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_mis = n_mis + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic has_par,
                            input logic par, input logic stop);
    rx = 1'b0;
    wait_cyc(64);
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      wait_cyc(64);
    end
    if (has_par) begin
      rx = par;
      wait_cyc(64);
    end
    rx = stop;
    t_stop = cyc;
    wait_cyc(64);
    rx = 1'b1;
    wait_cyc(64);
  endtask

  initial begin
    wait_cyc(5);
    check("rst_data",   32'(rx_data),       32'h0);
    check("rst_valid",  32'(rx_valid),      32'h0);
    check("rst_active", 32'(rx_active),     32'h0);
    check("rst_pe",     32'(rx_parity_err), 32'h0);
    check("rst_fe",     32'(rx_frame_err),  32'h0);
    check("rst_brk",    32'(rx_break),      32'h0);
    PRESETn = 1'b1;
    wait_cyc(40);

    // 8N1 0xA5
    v0 = v_cnt;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    check("t1_cnt",      32'(v_cnt - v0), 32'd1);
    check("t1_data",     32'(cap_data),   32'hA5);
    check("t1_pe",       32'(cap_pe),     32'h0);
    check("t1_fe",       32'(cap_fe),     32'h0);
    check("t1_brk",      32'(cap_brk),    32'h0);
    check("t1_prev_act", 32'(cap_prev_act), 32'h1);
    check("t1_act_at_v", 32'(cap_act),    32'h0);
    check("t1_lat",      32'((cap_cyc - t_stop >= 36) && (cap_cyc - t_stop <= 46)), 32'h1);
    check("t1_hold",     32'(rx_data),    32'hA5);

    // Glitch: 5 ticks low, then a real 0x3C frame
    v0 = v_cnt;
    rx = 1'b0;
    wait_cyc(20);
    rx = 1'b1;
    wait_cyc(200);
    check("t2_no_valid", 32'(v_cnt - v0), 32'd0);
    check("t2_idle",     32'(rx_active),  32'h0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    check("t2_cnt",  32'(v_cnt - v0), 32'd1);
    check("t2_data", 32'(cap_data),   32'h3C);
    check("t2_fe",   32'(cap_fe),     32'h0);

    // 7E1 / 7O1 with 0x41 (two ones: even parity bit 0, odd parity bit 1)
    lcr_wls = 2'b10; lcr_pen = 1'b1; lcr_eps = 1'b1;
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
    check("t3_bad_data", 32'(cap_data), 32'h41);
    check("t3_bad_pe",   32'(cap_pe),   32'h1);
    check("t3_bad_fe",   32'(cap_fe),   32'h0);
    send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1);
    check("t3_ok_data",  32'(cap_data), 32'h41);
    check("t3_ok_pe",    32'(cap_pe),   32'h0);
    lcr_eps = 1'b0;
    send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1);
    check("t3_odd_pe",   32'(cap_pe),   32'h1);
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
    check("t3_odd_ok",   32'(cap_pe),   32'h0);

    // 5N1 with word length changed mid-frame
    lcr_wls = 2'b00; lcr_pen = 1'b0; lcr_eps = 1'b0;
    v0 = v_cnt;
    fork
      send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1);
      begin
        wait_cyc(64 * 3);
        lcr_wls = 2'b11;
      end
    join
    check("t4_cnt",  32'(v_cnt - v0), 32'd1);
    check("t4_data", 32'(cap_data),   32'h1F);
    check("t4_fe",   32'(cap_fe),     32'h0);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
    check("t4_next8", 32'(cap_data),  32'hC3);

    // Break: line low for three frame times
    v0 = v_cnt;
    rx = 1'b0;
    wait_cyc(1920);
    check("t5_one_brk", 32'(v_cnt - v0), 32'd1);
    rx = 1'b1;
    wait_cyc(128);
    check("t5_cnt",  32'(v_cnt - v0), 32'd1);
    check("t5_data", 32'(cap_data),   32'h00);
    check("t5_brk",  32'(cap_brk),    32'h1);
    check("t5_fe",   32'(cap_fe),     32'h1);
    check("t5_pe",   32'(cap_pe),     32'h0);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
    check("t5_cnt2",  32'(v_cnt - v0), 32'd2);
    check("t5_data2", 32'(cap_data),   32'h55);
    check("t5_brk2",  32'(cap_brk),    32'h0);
    check("t5_fe2",   32'(cap_fe),     32'h0);

    // Reset during data bit 3 of 0x81
    v0 = v_cnt;
    rx = 1'b0; wait_cyc(64);
    rx = 1'b1; wait_cyc(64);
    rx = 1'b0; wait_cyc(64);
    rx = 1'b0; wait_cyc(64);
    rx = 1'b0; wait_cyc(32);
    check("t6_mid_act", 32'(rx_active), 32'h1);
    PRESETn = 1'b0;
    wait_cyc(3);
    check("t6_rst_data",   32'(rx_data),   32'h0);
    check("t6_rst_active", 32'(rx_active), 32'h0);
    check("t6_rst_valid",  32'(rx_valid),  32'h0);
    rx = 1'b1;
    wait_cyc(2);
    PRESETn = 1'b1;
    wait_cyc(200);
    check("t6_no_valid", 32'(v_cnt - v0), 32'd0);
    check("t6_data0",    32'(rx_data),    32'h0);
    check("t6_idle",     32'(rx_active),  32'h0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
    check("t6_cnt",  32'(v_cnt - v0), 32'd1);
    check("t6_data", 32'(cap_data),   32'h81);
    check("t6_fe",   32'(cap_fe),     32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
